// File: rtl/shift_exec_stage.sv
// Execute-stage sequencer driving one SHIFT32 shifter over one or two passes to
// build SLL/SRL/SRA/ROL/ROR, with valid/ready on both request and result sides.

module shift32 (
  input  logic [31:0] src,
  input  logic [31:0] amt,
  input  logic        lnr,
  output logic [31:0] out
);
  always_comb begin
    out = '0;
    if (amt < 32'd32) out = lnr ? (src << amt[4:0]) : (src >> amt[4:0]);
  end
endmodule

module shift_exec_stage #(
  parameter logic [31:0] ILLEGAL_RESULT = 32'h0000_0000,
  parameter int          CNT_W          = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [31:0]      data,
  input  logic [31:0]      amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      result,
  output logic             zero,
  output logic             illegal,
  output logic [CNT_W-1:0] op_count
);
  typedef enum logic [1:0] {IDLE, P1, P2, DONE} state_t;

  localparam logic [2:0] OP_SLL = 3'd0;
  localparam logic [2:0] OP_SRL = 3'd1;
  localparam logic [2:0] OP_SRA = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;

  state_t      state;
  logic [2:0]  op_q;
  logic [31:0] d_q, s_q, acc;
  logic [31:0] sh_src, sh_amt, sh_out, rot_comp, acc_or;
  logic        sh_lnr, illegal_op;

  assign illegal_op = (op_q > OP_ROR);
  // 32 - r evaluated at full width so r = 0 yields 32, which the shifter maps to 0.
  assign rot_comp   = 32'd32 - {27'd0, s_q[4:0]};
  assign acc_or     = acc | sh_out;

  // Pass operand selection: what the shifter sees depends on op and current pass.
  always_comb begin
    sh_src = d_q;
    sh_amt = s_q;
    sh_lnr = 1'b0;
    case (op_q)
      OP_SLL: sh_lnr = 1'b1;
      OP_SRA: if (state == P2) begin
        sh_src = {32{d_q[31]}};
        sh_amt = (s_q >= 32'd32) ? 32'd0 : (32'd32 - s_q);
        sh_lnr = 1'b1;
      end
      OP_ROL: begin
        sh_amt = (state == P2) ? rot_comp : {27'd0, s_q[4:0]};
        sh_lnr = (state != P2);
      end
      OP_ROR: begin
        sh_amt = (state == P2) ? rot_comp : {27'd0, s_q[4:0]};
        sh_lnr = (state == P2);
      end
      default: ;
    endcase
  end

  shift32 u_shift (.src(sh_src), .amt(sh_amt), .lnr(sh_lnr), .out(sh_out));

  // NOTE: sequential state uses non-blocking assignments only; every register,
  // including the latched operands, is cleared by the asynchronous reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      op_q     <= '0;
      d_q      <= '0;
      s_q      <= '0;
      acc      <= '0;
      zero     <= 1'b0;
      illegal  <= 1'b0;
      op_count <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_q  <= op;
          d_q   <= data;
          s_q   <= amt;
          state <= P1;
        end
        P1: begin
          if (illegal_op) begin
            acc     <= ILLEGAL_RESULT;
            zero    <= (ILLEGAL_RESULT == 32'd0);
            illegal <= 1'b1;
            state   <= DONE;
          end else begin
            acc     <= sh_out;
            zero    <= (sh_out == 32'd0);
            illegal <= 1'b0;
            state   <= (op_q == OP_SLL || op_q == OP_SRL) ? DONE : P2;
          end
        end
        P2: begin
          acc   <= acc_or;
          zero  <= (acc_or == 32'd0);
          state <= DONE;
        end
        DONE: if (out_ready) begin
          op_count <= op_count + CNT_W'(1);
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign result    = acc;
  assign out_valid = (state == DONE);
  // Gated by reset so the stage never advertises readiness while held in reset.
  assign in_ready  = (state == IDLE) && RST;
endmodule
